// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register file write port among R requesters,
// with a registered write stage and a per-register pending-write scoreboard.
// Optional macro RF_ARB_R0_DISCARD_EN: grant writes to register 0 but never commit them.
module rf_write_arbiter #(
  parameter int W = 16,
  parameter int N = 8,
  parameter int R = 4,
  localparam int AW = (N > 1) ? $clog2(N) : 1,
  localparam int RW = (R > 1) ? $clog2(R) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [R-1:0]    req_v_i,
  input  logic [R*AW-1:0] req_wa_i,
  input  logic [R*W-1:0]  req_wd_i,
  output logic [R-1:0]    req_rdy_o,
  input  logic            stall_i,
  output logic            wen_o,
  output logic [AW-1:0]   wa_o,
  output logic [W-1:0]    wd_o,
  output logic [N-1:0]    pending_o,
  output logic [RW-1:0]   rr_ptr_o
);

  logic          wen_q, wen_d;
  logic [AW-1:0] wa_q, wa_d;
  logic [W-1:0]  wd_q, wd_d;
  logic [N-1:0]  pending_q, pending_d;
  logic [RW-1:0] rr_ptr_q, rr_ptr_d;

  logic [R-1:0]  grant;
  logic [RW-1:0] sel_idx;
  logic [AW-1:0] sel_wa;
  logic [W-1:0]  sel_wd;
  logic          accept;
  logic          commit_req;

  // Rotating priority search; depends only on valids, stall, reset and the pointer.
  always_comb begin
    int   idx;
    logic found;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    if (!reset && !stall_i) begin
      for (int i = 0; i < R; i++) begin
        idx = int'(rr_ptr_q) + i;
        if (idx >= R) idx = idx - R;
        if (!found && req_v_i[idx[RW-1:0]]) begin
          grant[idx[RW-1:0]] = 1'b1;
          found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    sel_idx = '0;
    sel_wa  = '0;
    sel_wd  = '0;
    for (int k = 0; k < R; k++) begin
      if (grant[k]) begin
        sel_idx = RW'(k);
        sel_wa  = req_wa_i[k*AW +: AW];
        sel_wd  = req_wd_i[k*W +: W];
      end
    end
  end

  assign accept = |grant;

`ifdef RF_ARB_R0_DISCARD_EN
  assign commit_req = accept && (sel_wa != '0);
`else
  assign commit_req = accept;
`endif

  // Set after clear, so a same-cycle accept and commit of one address leaves it pending.
  always_comb begin
    wen_d     = commit_req;
    wa_d      = wa_q;
    wd_d      = wd_q;
    rr_ptr_d  = rr_ptr_q;
    pending_d = pending_q;
    if (accept) begin
      wa_d     = sel_wa;
      wd_d     = sel_wd;
      rr_ptr_d = (sel_idx == RW'(R - 1)) ? '0 : sel_idx + RW'(1);
    end
    if (wen_q) pending_d[wa_q] = 1'b0;
    if (commit_req) pending_d[sel_wa] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wen_q     <= 1'b0;
      wa_q      <= '0;
      wd_q      <= '0;
      pending_q <= '0;
      rr_ptr_q  <= '0;
    end else begin
      wen_q     <= wen_d;
      wa_q      <= wa_d;
      wd_q      <= wd_d;
      pending_q <= pending_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  assign req_rdy_o = grant;
  assign wen_o     = wen_q;
  assign wa_o      = wa_q;
  assign wd_o      = wd_q;
  assign pending_o = pending_q;
  assign rr_ptr_o  = rr_ptr_q;

endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Round-robin arbiter that shares the register file's single write port among R writeback requesters (ALU, load unit, move/immediate path, etc.). Each cycle it grants at most one valid request, registers the winning address/data, and drives the register file's write-enable, write-address and write-data one cycle later. It also keeps a per-register pending scoreboard, so decode can stall on registers whose writes are in flight.

## Interface
Parameters:
- W, 16, data width; matches register file word width
- N, 8, number of registers; AW = $clog2(N)
- R, 4, number of requesters (2..8); RW = $clog2(R)

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  asynchronous, active-high reset
- req_v_i  in  R  request valid, one bit per requester
- req_wa_i  in  R*AW  packed write addresses; requester k at [k*AW +: AW]
- req_wd_i  in  R*W  packed write data; requester k at [k*W +: W]
- req_rdy_o  out  R  grant, combinational, one-hot or zero; request k is accepted when req_v_i[k] & req_rdy_o[k]
- stall_i  in  1  when high, no grant is issued that cycle
- wen_o  out  1  register file write enable (registered)
- wa_o  out  AW  register file write address (registered)
- wd_o  out  W  register file write data (registered)
- pending_o  out  N  bit i high means a write to register i is accepted but not yet committed
- rr_ptr_o  out  RW  current highest-priority requester, for debug

## Operation
- Arbitration is combinational from req_v_i, stall_i and rr_ptr:
  - Search requesters rr_ptr, rr_ptr+1, … mod R.
  - The first one with req_v_i set gets req_rdy_o.
  - stall_i=1 forces req_rdy_o=0.
- On an accept of requester k:
  - The output stage loads wa_o/wd_o from requester k, and wen_o=1 next cycle.
  - rr_ptr becomes (k+1) mod R.
  - If R is not a power of two, the wrap is explicit.
- With no accept:
  - wen_o=0 next cycle.
  - wa_o/wd_o hold their previous values.
  - rr_ptr is unchanged.
- Requesters hold req_wa_i/req_wd_i stable while valid and not yet accepted. Deasserting valid without acceptance is permitted and has no effect.
- Pending scoreboard:
  - On accept of address a, set pending[a].
  - In a cycle where wen_o=1 with wa_o=a, clear pending[a]. That is the cycle the register file commits.
  - If the same address is both accepted and committed in one cycle, set wins and the bit stays 1.
- Two requesters targeting the same address in the same cycle: only the winner is accepted. The loser is accepted in a later cycle, so writes land in grant order.
- Reset:
  - wen_o=0, wa_o=0, wd_o=0, pending_o=0, rr_ptr=0.
  - req_rdy_o is combinationally 0 while reset is high.
  - A write accepted the cycle before reset asserts is lost, and its pending bit is cleared.

## Timing
- Latency: accepted in cycle t → wen_o/wa_o/wd_o valid in cycle t+1 → register file updated at the end of t+1. Data is readable combinationally from the register file in t+2.
- pending[a] is 1 in cycle t+1 and 0 in t+2, unless re-accepted.
- Throughput: one write per cycle, sustained.
- Fairness: a requester holding valid is granted within R cycles when stall_i=0.
- req_rdy_o has a combinational path from req_v_i and stall_i only. There is no path from wa/wd inputs to ready.

## Configuration
- RF_ARB_R0_DISCARD_EN defined:
  - A request with address 0 is still granted (req_rdy_o=1) and advances rr_ptr.
  - It does not produce wen_o=1, and pending[0] is never set.
  - Rationale: register 0 always reads as zero, so a write to it is wasted.
- Not defined: address-0 requests are forwarded like any other. wen_o=1 with wa_o=0, and pending[0] is tracked normally.

## Test plan
- Reset mid-operation:
  - Stimulus: requesters 0–3 valid continuously, then reset asserted asynchronously.
  - Required: wen_o, wa_o, wd_o and pending_o are all 0 immediately; after release, the first grant goes to requester 0.
- Round-robin:
  - Stimulus: req_v_i=4'b1111 for 8 cycles with distinct addresses 1..4.
  - Required: grants go 0,1,2,3,0,1,2,3; wen_o=1 from cycle 2 onward; wa_o follows 1,2,3,4,….
- Latency and scoreboard:
  - Stimulus: requester 2 writes 0xBEEF to register 5 in cycle t.
  - Required: wen_o=1, wa_o=5, wd_o=0xBEEF in t+1; pending_o[5]=1 in t+1 and 0 in t+2.
- Same-address conflict:
  - Stimulus: requesters 1 and 3 both write register 6 (0x1111, 0x3333) with rr_ptr=0.
  - Required: requester 1 commits first, then 3; final value 0x3333; pending_o[6] stays 1 across both and clears after the second commit.
- Stall:
  - Stimulus: stall_i=1 for 3 cycles with req_v_i=4'b0100.
  - Required: req_rdy_o=0 and wen_o=0 throughout, rr_ptr unchanged; requester 2 is granted in the cycle stall_i drops.
- Register-0 write:
  - Stimulus: request to address 0 with data 0x00FF.
  - Required with RF_ARB_R0_DISCARD_EN: grant issued, wen_o stays 0, pending_o=0.
  - Required without it: wen_o=1, wa_o=0, wd_o=0x00FF.
